uart_shift_core: RTL and testbench
==================================

# uart_shift_core

Parametrised full-duplex serial shift core: a TX shift register/state machine and an independent RX shift register/state machine share one programmable baud generator. It sits behind the peripheral's control/status register file and converts parallel bytes to asynchronous serial frames and back. Relative to the earlier fixed-format shifter, it adds:

- configurable data width, parity and stop bits;
- 16x oversampled receive;
- valid/ready handshakes;
- error and overrun reporting.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 2, stop bits, legal 1 or 2
- PARITY_EN, 0, 1 = parity bit after data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
- OVS, 16, oversample ticks per bit, even, >=4
- DIV_W, 16, width of baud divisor

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- brr  in  DIV_W  baud divisor; one oversample tick every brr+1 clk cycles
- tx_data  in  DATA_BITS  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  core can accept a word (TX idle)
- tx_busy  out  1  frame in progress on tx
- tx  out  1  serial out, idle high
- rx  in  1  serial in, asynchronous
- rx_data  out  DATA_BITS  received word
- rx_valid  out  1  rx_data holds an unread word
- rx_ready  in  1  consumer takes word
- rx_frame_err  out  1  first stop bit sampled low, qualified by rx_valid
- rx_parity_err  out  1  parity mismatch, qualified by rx_valid
- rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid=1; new frame discarded

## Operation
Reset values:
- tx=1, tx_ready=1, tx_busy=0.
- rx_valid=0, rx_data=0, both error flags=0, rx_overrun=0.
- Sync flops=1, all counters=0, both FSMs in IDLE.

Baud generator:
- Free-running counter; tick when counter==brr, then counter clears to 0.
- A brr change takes effect from the current count; if the counter is already above brr, it runs on to wrap.
- brr=0 gives a tick every cycle.

TX FSM, states IDLE -> START -> DATA -> PARITY (if PARITY_EN) -> STOP -> IDLE:
- Accept when tx_valid && tx_ready. Then latch the shift register, clear tx_ready, set tx_busy, and clear the TX tick sub-counter.
- Every TX state lasts OVS ticks per bit.
- Data goes out LSB first, shifting right.
- Parity is the XOR of data bits, inverted if PARITY_ODD.
- STOP drives 1 for STOP_BITS bits, then returns to IDLE with tx_ready=1 and tx_busy=0.
- tx_valid while busy is ignored; no queueing.

RX FSM, states IDLE -> START -> DATA -> PARITY (if PARITY_EN) -> STOP -> IDLE:
- rx passes through a 2-flop synchroniser before use.
- IDLE: a synced low sample moves to START and clears the tick count.
- START: after OVS/2 ticks, re-sample. If low, go to DATA; if high, treat it as a glitch and return to IDLE with no flags.
- DATA: sample every OVS ticks (mid-bit) and shift into the MSB, so the LSB ends at bit 0.
- PARITY: sample and compare.
- STOP: sample the first stop bit only. Then:
  - If rx_valid=0: load rx_data and the errors, and set rx_valid.
  - Else: pulse rx_overrun and keep the old data and flags.
  - Return to IDLE immediately; the next start bit may be detected from the next cycle.
- rx_valid clears on the cycle after rx_valid && rx_ready.
- A frame completing in the same cycle as a read is loaded, with no overrun.
- Frame and parity errors still deliver data.

## Timing
- Bit period = OVS*(brr+1) cycles.
- TX frame = (1 + DATA_BITS + PARITY_EN + STOP_BITS) bit periods.
- tx falls on the cycle after the accept edge.
- tx_ready rises the cycle after the last stop bit ends.
- RX latency: rx_valid rises 2 (sync) + up to brr+1 (tick alignment) cycles after the mid-point of the first stop bit.
- rst_n low mid-frame:
  - tx returns to 1 asynchronously.
  - Any partial RX frame is lost.
  - Outputs take their reset values.

## Test plan
- Loopback tx->rx, default params, brr=3: send 0xA5 -> tx low for 64 cycles, frame 704 cycles; rx_valid with rx_data=0xA5, both errors 0.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1 on the line; received with rx_parity_err=0. Force the line parity to 0 -> rx_parity_err=1, data 0x07.
- Drive rx frame with first stop bit low -> rx_valid=1, rx_frame_err=1, data still delivered.
- rx low pulse shorter than OVS/2 ticks (e.g. 20 cycles at brr=3) -> no rx_valid, FSM back in IDLE.
- Two frames 0x11, 0x22 received with rx_ready=0 -> rx_data=0x11, one rx_overrun pulse. Then rx_ready=1 for 1 cycle -> rx_valid=0 next cycle.
- Assert rst_n=0 during DATA of a TX frame -> tx=1 and tx_ready=1 immediately. After release, a new 0x3C sends cleanly and a new RX frame receives cleanly.

Source files
------------

// File: rtl/uart_shift_core.sv
// Full-duplex UART shift core: TX and RX framers sharing one programmable oversample tick.
// Frame format (data width, parity, stop bits, oversample ratio) is fixed by parameters.
module uart_shift_core #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 2,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     brr,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int TICK_W = $clog2(OVS);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVS / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD       = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] S_AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;

    logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic                 tick;

    logic [2:0]           tx_state_q, tx_state_d;
    logic [TICK_W-1:0]    tx_tick_q, tx_tick_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;

    logic                 rx_meta_q, rx_sync_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [TICK_W-1:0]    rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_cur_q, rx_perr_cur_d;
    logic                 rx_done;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_overrun_q, rx_overrun_d;

    // A brr lowered below the current count lets the counter wrap through zero.
    assign tick       = (baud_cnt_q == brr);
    assign baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q == S_IDLE) begin
            if (tx_valid) begin
                tx_state_d = S_START;
                tx_tick_d  = '0;
                tx_bit_d   = '0;
                tx_shift_d = tx_data;
                tx_par_d   = (^tx_data) ^ ODD;
            end
        end else if (tick) begin
            if (tx_tick_q != TICK_LAST) begin
                tx_tick_d = tx_tick_q + TICK_W'(1);
            end else begin
                tx_tick_d = '0;
                case (tx_state_q)
                    S_START: tx_state_d = S_DATA;
                    S_DATA: begin
                        tx_shift_d = tx_shift_q >> 1;
                        if (tx_bit_q == DATA_LAST) begin
                            tx_bit_d   = '0;
                            tx_state_d = S_AFTER_DATA;
                        end else begin
                            tx_bit_d = tx_bit_q + BIT_W'(1);
                        end
                    end
                    S_PARITY: tx_state_d = S_STOP;
                    S_STOP: begin
                        if (tx_bit_q == STOP_LAST) tx_state_d = S_IDLE;
                        else                       tx_bit_d   = tx_bit_q + BIT_W'(1);
                    end
                    default: tx_state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (tx_state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift_q[0];
            S_PARITY: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    assign tx_ready = (tx_state_q == S_IDLE);
    assign tx_busy  = ~tx_ready;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tick_d     = rx_tick_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_perr_cur_d = rx_perr_cur_q;
        rx_done       = 1'b0;
        if (rx_state_q == S_IDLE) begin
            if (!rx_sync_q) begin
                rx_state_d    = S_START;
                rx_tick_d     = '0;
                rx_perr_cur_d = 1'b0;
            end
        end else if (tick) begin
            if (rx_state_q == S_START) begin
                // Half a bit in: a line that is high again was only a glitch.
                if (rx_tick_q == TICK_HALF) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_tick_d = rx_tick_q + TICK_W'(1);
                end
            end else if (rx_tick_q != TICK_LAST) begin
                rx_tick_d = rx_tick_q + TICK_W'(1);
            end else begin
                rx_tick_d = '0;
                case (rx_state_q)
                    S_DATA: begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == DATA_LAST) rx_state_d = S_AFTER_DATA;
                        else                       rx_bit_d   = rx_bit_q + BIT_W'(1);
                    end
                    S_PARITY: begin
                        rx_perr_cur_d = rx_sync_q ^ (^rx_shift_q) ^ ODD;
                        rx_state_d    = S_STOP;
                    end
                    default: begin
                        rx_done    = 1'b1;
                        rx_state_d = S_IDLE;
                    end
                endcase
            end
        end

        rx_data_d    = rx_data_q;
        rx_ferr_d    = rx_ferr_q;
        rx_perr_d    = rx_perr_q;
        rx_valid_d   = rx_valid_q & ~rx_ready;
        rx_overrun_d = 1'b0;
        // A read in the completing cycle frees the holding register in time.
        if (rx_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                rx_ferr_d  = ~rx_sync_q;
                rx_perr_d  = rx_perr_cur_q;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q    <= '0;
            tx_state_q    <= S_IDLE;
            tx_tick_q     <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_perr_cur_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            baud_cnt_q    <= baud_cnt_d;
            tx_state_q    <= tx_state_d;
            tx_tick_q     <= tx_tick_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_perr_cur_q <= rx_perr_cur_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_perr_q     <= rx_perr_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_shift_core.sv
// Bench for uart_shift_core: a default-format instance and an even-parity instance,
// each with an expected-frame queue drained by an independent receive monitor.
module tb_uart_shift_core;

    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] brr = '0;

    always #5 clk = ~clk;

    logic [7:0] tx_data_a, rx_data_a, tx_data_p, rx_data_p;
    logic tx_valid_a, tx_ready_a, tx_busy_a, tx_a, rx_a, rx_valid_a, rx_ready_a;
    logic ferr_a, perr_a, ovr_a, loop_a, line_a;
    logic tx_valid_p, tx_ready_p, tx_busy_p, tx_p, rx_p, rx_valid_p, rx_ready_p;
    logic ferr_p, perr_p, ovr_p, loop_p, line_p;

    assign rx_a = loop_a ? tx_a : line_a;
    assign rx_p = loop_p ? tx_p : line_p;

    uart_shift_core dut_a (
        .clk(clk), .rst_n(rst_n), .brr(brr),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .tx_busy(tx_busy_a), .tx(tx_a), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_overrun(ovr_a)
    );

    uart_shift_core #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .brr(brr),
        .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
        .tx_busy(tx_busy_p), .tx(tx_p), .rx(rx_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .rx_frame_err(ferr_p), .rx_parity_err(perr_p), .rx_overrun(ovr_p)
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t e_a, e_p;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ovr_seen_a = 0;
    int   ovr_seen_p = 0;
    logic prev_a = 1'b0;
    logic prev_p = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Parity bit that makes the total count of ones even.
    function automatic logic even_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rx_valid_a && !prev_a) begin
            if (q_a.size() == 0) begin
                check("spurious_rx_valid_a", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("rx_data_a", 32'(rx_data_a), 32'(e_a.data));
                check("rx_frame_err_a", 32'(ferr_a), 32'(e_a.ferr));
                check("rx_parity_err_a", 32'(perr_a), 32'(e_a.perr));
            end
        end
        if (rst_n && ovr_a) ovr_seen_a++;
        prev_a = rx_valid_a;
    end

    always @(negedge clk) begin
        if (rst_n && rx_valid_p && !prev_p) begin
            if (q_p.size() == 0) begin
                check("spurious_rx_valid_p", 32'd1, 32'd0);
            end else begin
                e_p = q_p.pop_front();
                check("rx_data_p", 32'(rx_data_p), 32'(e_p.data));
                check("rx_frame_err_p", 32'(ferr_p), 32'(e_p.ferr));
                check("rx_parity_err_p", 32'(perr_p), 32'(e_p.perr));
            end
        end
        if (rst_n && ovr_p) ovr_seen_p++;
        prev_p = rx_valid_p;
    end

    // Looped-back transmit: checks line timing, parity bit and queues the echo.
    task automatic send_tx(input bit sel, input logic [7:0] d);
        int bp = OVS * (int'(brr) + 1);
        int bits = sel ? 12 : 11;
        int n = 0;
        int low_len = 0;
        int frame_len = 0;
        bit seen_high = 0;
        logic par_line = 1'bx;
        while (!(sel ? tx_ready_p : tx_ready_a) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            check("tx_ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (sel) begin tx_data_p = d; tx_valid_p = 1'b1; end
        else     begin tx_data_a = d; tx_valid_a = 1'b1; end
        @(posedge clk);
        if (sel) q_p.push_back('{d, 1'b0, 1'b0});
        else     q_a.push_back('{d, 1'b0, 1'b0});
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_valid_p = 1'b0;
        check("tx_busy_in_frame", 32'(sel ? tx_busy_p : tx_busy_a), 32'd1);
        while (!(sel ? tx_ready_p : tx_ready_a) && frame_len < bits * bp + 100) begin
            if (!seen_high && !(sel ? tx_p : tx_a)) low_len++;
            else seen_high = 1;
            if (sel && frame_len == 9 * bp + bp / 2) par_line = tx_p;
            frame_len++;
            @(negedge clk);
        end
        check_rng("tx_frame_len", frame_len, bits * bp - int'(brr), bits * bp);
        if (d[0]) check_rng("tx_start_len", low_len, (OVS - 1) * (int'(brr) + 1) + 1, bp);
        if (sel) check("tx_parity_bit", 32'(par_line), 32'(even_par(d)));
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        if (sel) line_p = v;
        else     line_a = v;
        repeat (n) @(negedge clk);
    endtask

    // Bench-built serial frame. A bad first stop bit is driven low only over its first
    // three quarters so the line is high again when a fresh start bit would be confirmed.
    task automatic drive_rx(input bit sel, input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input bit push);
        int bp = OVS * (int'(brr) + 1);
        if (push) begin
            if (sel) q_p.push_back('{d, bad_stop, bad_par});
            else     q_a.push_back('{d, bad_stop, 1'b0});
        end
        hold(sel, 1'b0, bp);
        for (int i = 0; i < 8; i++) hold(sel, d[i], bp);
        if (sel) hold(sel, even_par(d) ^ bad_par, bp);
        if (bad_stop) begin
            hold(sel, 1'b0, bp * 3 / 4);
            hold(sel, 1'b1, bp - bp * 3 / 4);
        end else begin
            hold(sel, 1'b1, bp);
        end
        hold(sel, 1'b1, 2 * bp);
    endtask

    task automatic random_round();
        logic [7:0] d1, d2, d3, d4;
        bit bp1, bs1, bs3;
        d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom); d4 = 8'($urandom);
        bp1 = 1'($urandom); bs1 = 1'($urandom); bs3 = 1'($urandom);
        loop_a = 1'b1;
        loop_p = 1'b0;
        fork
            send_tx(1'b0, d1);
            drive_rx(1'b1, d2, bp1, bs1, 1'b1);
        join
        loop_a = 1'b0;
        loop_p = 1'b1;
        fork
            drive_rx(1'b0, d3, 1'b0, bs3, 1'b1);
            send_tx(1'b1, d4);
        join
    endtask

    initial begin
        int bp;
        int base;
        int n;
        tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b1; loop_a = 1'b1; line_a = 1'b1;
        tx_data_p = '0; tx_valid_p = 1'b0; rx_ready_p = 1'b1; loop_p = 1'b1; line_p = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx", 32'(tx_a), 32'd1);
        check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
        check("rst_tx_busy", 32'(tx_busy_a), 32'd0);
        check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        check("rst_rx_data", 32'(rx_data_a), 32'd0);
        check("rst_frame_err", 32'(ferr_a), 32'd0);
        check("rst_parity_err", 32'(perr_a), 32'd0);
        check("rst_overrun", 32'(ovr_a), 32'd0);
        check("rst_tx_p", 32'(tx_p), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // brr only ever rises so the baud counter never has to wrap through 2^16.
        brr = 16'd0;
        for (int i = 0; i < 10; i++) random_round();
        brr = 16'd1;
        for (int i = 0; i < 4; i++) random_round();
        brr = 16'd3;
        bp = OVS * 4;

        loop_a = 1'b1;
        send_tx(1'b0, 8'hA5);

        loop_p = 1'b1;
        send_tx(1'b1, 8'h07);
        loop_p = 1'b0;
        drive_rx(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);

        loop_a = 1'b0;
        drive_rx(1'b0, 8'hC9, 1'b0, 1'b1, 1'b1);

        hold(1'b0, 1'b0, 20);
        hold(1'b0, 1'b1, 3 * bp);
        check("glitch_rx_valid", 32'(rx_valid_a), 32'd0);
        drive_rx(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);

        rx_ready_a = 1'b0;
        base = ovr_seen_a;
        drive_rx(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        drive_rx(1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        check("ovr_rx_valid", 32'(rx_valid_a), 32'd1);
        check("ovr_rx_data", 32'(rx_data_a), 32'h11);
        check("ovr_pulses", 32'(ovr_seen_a - base), 32'd1);
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        check("read_clears_valid", 32'(rx_valid_a), 32'd0);
        rx_ready_a = 1'b1;

        loop_a = 1'b1;
        n = 0;
        while (!tx_ready_a && n < 20000) begin @(negedge clk); n++; end
        tx_data_a = 8'h5A;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_a), 32'd1);
        check("mid_rst_tx_ready", 32'(tx_ready_a), 32'd1);
        check("mid_rst_tx_busy", 32'(tx_busy_a), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid_a), 32'd0);
        q_a.delete();
        q_p.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loop_p = 1'b0;
        fork
            send_tx(1'b0, 8'h3C);
            drive_rx(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        join

        n = 0;
        while ((q_a.size() != 0 || q_p.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_p_drained", 32'(q_p.size()), 32'd0);
        check("no_overrun_p", 32'(ovr_seen_p), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
